// File: rtl/bram_transpose_ctrl.sv
// bram_transpose_ctrl: double-buffered N x N tile transposer around a dual-port BRAM.
// Input elements arrive row-major and are written through port A into one of two
// banks. Once a bank holds a full tile, it is read column-major through port B into a
// 2-entry output FIFO. The FIFO gives the read path enough skid for 1 element/cycle
// under back-pressure.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid/in_data/in_ready      row-major element input (valid/ready)
//   out_valid/out_data/out_last    column-major element output (valid/ready), last marks tile end
//   out_ready                      output consumer ready
//   bram_*_a                       port A: write-only (ren tied low)
//   bram_*_b, bram_dout_b          port B: read-only (wen tied low), one-cycle read latency
//   busy                           a bank is full, a read is in flight, or the FIFO is non-empty
module bram_transpose_ctrl #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned TILE_DIM        = 8,
    parameter int unsigned BRAM_ADDR_WIDTH = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_addr_a,
    output logic [DATA_WIDTH-1:0]      bram_din_a,
    output logic                       bram_wen_a,
    output logic                       bram_ren_a,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_addr_b,
    output logic                       bram_wen_b,
    output logic                       bram_ren_b,
    input  logic [DATA_WIDTH-1:0]      bram_dout_b,
    output logic                       busy
);

    localparam int unsigned LOG_N = $clog2(TILE_DIM);
    localparam int unsigned IDX_W = 2 * LOG_N;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TILE_DIM * TILE_DIM - 1);

    logic [1:0]            full_q, full_d;
    logic                  wr_bank_q, wr_bank_d;
    logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic [DATA_WIDTH-1:0] fdata_q [2];
    logic [DATA_WIDTH-1:0] fdata_d [2];
    logic                  flast_q [2];
    logic                  flast_d [2];
    logic                  fwptr_q, fwptr_d;
    logic                  frptr_q, frptr_d;
    logic [1:0]            fcnt_q, fcnt_d;

    logic                  in_hs;
    logic                  pop;
    logic                  rd_issue;
    logic [2:0]            occupancy;

    // Handshake, read-issue and BRAM port drive; rst gating keeps strobes low during reset.
    always_comb begin
        in_ready    = !full_q[wr_bank_q];
        in_hs       = in_valid && in_ready && !rst;
        out_valid   = (fcnt_q != 2'd0);
        pop         = out_valid && out_ready;
        // Entries the FIFO will hold once the in-flight read lands, net of this cycle's pop.
        occupancy   = 3'(fcnt_q) + 3'(inflight_q) - 3'(pop);
        rd_issue    = full_q[rd_bank_q] && (occupancy < 3'd2) && !rst;

        bram_wen_a  = in_hs;
        bram_ren_a  = 1'b0;
        bram_addr_a = BRAM_ADDR_WIDTH'({wr_bank_q, wr_idx_q});
        bram_din_a  = in_hs ? in_data : '0;

        bram_wen_b  = 1'b0;
        bram_ren_b  = rd_issue;
        // Swapping the row/column halves of rd_idx walks the stored tile column by column.
        bram_addr_b = BRAM_ADDR_WIDTH'({rd_bank_q, rd_idx_q[LOG_N-1:0], rd_idx_q[IDX_W-1:LOG_N]});

        out_data    = out_valid ? fdata_q[frptr_q] : '0;
        out_last    = out_valid && flast_q[frptr_q];
        busy        = (full_q != 2'b00) || inflight_q || out_valid;
    end

    // Next-state for bank bookkeeping, read pipeline and output FIFO.
    always_comb begin
        full_d          = full_q;
        wr_bank_d       = wr_bank_q;
        wr_idx_d        = wr_idx_q;
        rd_bank_d       = rd_bank_q;
        rd_idx_d        = rd_idx_q;
        inflight_d      = rd_issue;
        inflight_last_d = rd_issue && (rd_idx_q == IDX_LAST);
        fdata_d         = fdata_q;
        flast_d         = flast_q;
        fwptr_d         = fwptr_q;
        frptr_d         = frptr_q;
        fcnt_d          = fcnt_q + 2'(inflight_q) - 2'(pop);

        if (in_hs) begin
            if (wr_idx_q == IDX_LAST) begin
                wr_idx_d          = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end else begin
                wr_idx_d = wr_idx_q + IDX_W'(1);
            end
        end

        // Writer and reader always own different banks, so set and clear never collide.
        if (rd_issue) begin
            if (rd_idx_q == IDX_LAST) begin
                rd_idx_d          = '0;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end else begin
                rd_idx_d = rd_idx_q + IDX_W'(1);
            end
        end

        if (inflight_q) begin
            fdata_d[fwptr_q] = bram_dout_b;
            flast_d[fwptr_q] = inflight_last_q;
            fwptr_d          = !fwptr_q;
        end
        if (pop) begin
            frptr_d = !frptr_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q          <= '0;
            wr_bank_q       <= 1'b0;
            wr_idx_q        <= '0;
            rd_bank_q       <= 1'b0;
            rd_idx_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fdata_q[i] <= '0;
                flast_q[i] <= 1'b0;
            end
            fwptr_q         <= 1'b0;
            frptr_q         <= 1'b0;
            fcnt_q          <= '0;
        end else begin
            full_q          <= full_d;
            wr_bank_q       <= wr_bank_d;
            wr_idx_q        <= wr_idx_d;
            rd_bank_q       <= rd_bank_d;
            rd_idx_q        <= rd_idx_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            fdata_q         <= fdata_d;
            flast_q         <= flast_d;
            fwptr_q         <= fwptr_d;
            frptr_q         <= frptr_d;
            fcnt_q          <= fcnt_d;
        end
    end

endmodule

// File: tb/tb_bram_transpose_ctrl.sv
// Testbench for bram_transpose_ctrl: a tile-level reference model turns each accepted
// input tile into its expected column-major output sequence on a scoreboard queue, and a
// monitor pops and compares every output handshake. A simple BRAM model serves port B.
module tb_bram_transpose_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned N  = 8;
    localparam int unsigned AW = 11;
    localparam int unsigned NN = N * N;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready;
    logic [AW-1:0] bram_addr_a;
    logic [DW-1:0] bram_din_a;
    logic          bram_wen_a;
    logic          bram_ren_a;
    logic [AW-1:0] bram_addr_b;
    logic          bram_wen_b;
    logic          bram_ren_b;
    logic [DW-1:0] bram_dout_b;
    logic          busy;

    bram_transpose_ctrl #(.DATA_WIDTH(DW), .TILE_DIM(N), .BRAM_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .bram_addr_a(bram_addr_a), .bram_din_a(bram_din_a), .bram_wen_a(bram_wen_a),
        .bram_ren_a(bram_ren_a), .bram_addr_b(bram_addr_b), .bram_wen_b(bram_wen_b),
        .bram_ren_b(bram_ren_b), .bram_dout_b(bram_dout_b), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous dual-port BRAM model: write on A, registered read on B.
    logic [DW-1:0] mem [1 << AW];
    always @(posedge clk) begin
        if (bram_wen_a) mem[bram_addr_a] <= bram_din_a;
        if (bram_ren_b) bram_dout_b <= mem[bram_addr_b];
    end

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t          exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            or_prob = 100;
    int            seq_val = 0;

    logic [DW-1:0] tile_m [NN];
    int            wr_idx_m = 0;
    int            wr_bank_m = 0;
    int            hs_total = 0;
    int            last_hs_cyc = 0;
    bit            lat_arm = 0;
    int            lat_val = -1;
    bit            stream_mode = 0;
    int            stream_base = 0;
    int            stream_drops = 0;
    int            stream_outs = 0;
    int            first_out_cyc = 0;
    int            last_out_cyc = 0;
    bit            prev_hold = 0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Random output back-pressure, re-drawn each cycle.
    initial out_ready = 1'b1;
    always begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 99) < or_prob);
    end

    // Monitor: reference model update on input handshakes, scoreboard check on output handshakes.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("rst_ctrl", {in_ready, out_valid, out_last, bram_wen_a, bram_ren_b, busy, bram_ren_a, bram_wen_b},
                  {1'b1, 7'd0});
            check("rst_bus", {bram_addr_a, bram_addr_b, bram_din_a, out_data}, 0);
            exp_q.delete();
            wr_idx_m  = 0;
            wr_bank_m = 0;
            prev_hold = 0;
        end else begin
            check("tied_ports", {bram_wen_b, bram_ren_a}, 0);
            check("wen_a", bram_wen_a, in_valid && in_ready);
            if (prev_hold)
                check("hold_stable", {out_valid, out_last, out_data}, {1'b1, prev_last, prev_data});
            if (in_valid && in_ready) begin
                check("addr_a", bram_addr_a, wr_bank_m * NN + wr_idx_m);
                check("din_a", bram_din_a, in_data);
                tile_m[wr_idx_m] = in_data;
                last_hs_cyc = cyc;
                hs_total++;
                if (wr_idx_m == NN - 1) begin
                    for (int c = 0; c < N; c++)
                        for (int r = 0; r < N; r++)
                            exp_q.push_back('{d: tile_m[r * N + c], l: (r == N - 1) && (c == N - 1)});
                    wr_idx_m  = 0;
                    wr_bank_m = 1 - wr_bank_m;
                end else begin
                    wr_idx_m++;
                end
            end
            if (stream_mode && in_valid && !in_ready && (hs_total - stream_base) >= NN)
                stream_drops++;
            if (out_valid && lat_arm) begin
                lat_val = cyc - last_hs_cyc;
                lat_arm = 0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", {out_last, out_data}, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_elem", {out_last, out_data}, {e.l, e.d});
                end
                if (stream_mode) begin
                    if (stream_outs == 0) first_out_cyc = cyc;
                    last_out_cyc = cyc;
                    stream_outs++;
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
        end
    end

    // Offer n elements with valid probability pv; sequential or random data.
    task automatic send(input int n, input int pv, input bit seq);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 20000) begin
            in_valid = ($urandom_range(0, 99) < pv);
            in_data  = seq ? DW'(seq_val) : DW'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) begin
                sent++;
                seq_val++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        check("send_timeout", sent, n);
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((exp_q.size() != 0 || busy) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check("drain_left", exp_q.size(), 0);
        check("drain_timeout", g >= 3000, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (3) @(negedge clk);
        #2;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Single tile, sequential data, latency of first output.
        seq_val = 0;
        lat_arm = 1;
        send(NN, 100, 1);
        wait_drain();
        check("first_out_latency", lat_val, 3);

        // Four tiles back-to-back: no input stalls after tile 0, no output gaps.
        seq_val      = 0;
        stream_base  = hs_total;
        stream_outs  = 0;
        stream_drops = 0;
        stream_mode  = 1;
        send(4 * NN, 100, 1);
        wait_drain();
        stream_mode = 0;
        check("stream_in_stalls", stream_drops, 0);
        check("stream_out_count", stream_outs, 4 * NN);
        check("stream_out_span", last_out_cyc - first_out_cyc, 4 * NN - 1);

        // Full back-pressure: both banks fill, input stalls, FIFO head holds element 0.
        or_prob = 0;
        @(posedge clk);
        #1;
        seq_val = 0;
        send(2 * NN, 100, 1);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        repeat (5) @(negedge clk);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_out_head", out_data, 0);
        check("bp_busy", busy, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        or_prob  = 100;
        wait_drain();

        // Random valid and ready over ten tiles of random data.
        or_prob = 50;
        send(10 * NN, 60, 0);
        or_prob = 100;
        wait_drain();

        // Asynchronous reset mid-tile, then a fresh tile must come out alone.
        seq_val = 0;
        send(30, 100, 1);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        #2;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        seq_val = 100;
        send(NN, 100, 1);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
